// File: rtl/adder_32bit_arbiter_if.sv
// Bundle of the requester-side and result-side handshakes of the shared adder
// arbiter. The arbiter takes the slave view; producers/consumer take master.
interface adder_32bit_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_sum;
  logic            res_c32;
  logic [IDW-1:0]  res_id;
  logic [15:0]     op_count;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_c32, res_id, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_c32, res_id, op_count
  );
endinterface

// File: rtl/adder_32bit_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among N requesters.
// The winning operand pair is summed and captured, together with the winner's
// index, in a one-entry result register that drains on its own handshake.

// Plain 32-bit adder with carry-in tied to zero.
module adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        C32
);
  assign {C32, S} = {1'b0, A} + {1'b0, B};
endmodule

module adder_32bit_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_32bit_arbiter_if.slave bus
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] grant_id;
  logic           grant_found;
  logic           free;
  logic           xfer;
  logic [31:0]    op_a;
  logic [31:0]    op_b;
  logic [31:0]    sum;
  logic           c32;

  logic           res_valid_q;
  logic [31:0]    res_sum_q;
  logic           res_c32_q;
  logic [IDW-1:0] res_id_q;
  logic [15:0]    op_count_q;

  // The slot can take a new result if empty or being drained this cycle.
  assign free = !res_valid_q || bus.res_ready;
  assign xfer = rst_n && free && grant_found;

  // Scan req_valid upward from ptr with wrap; the first set bit wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % N);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // Grant is one-hot on the winner only when the slot is free and not in reset.
  always_comb begin
    bus.req_ready = '0;
    if (xfer) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  // Steer the winner's operands into the single shared adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_id == IDW'(k)) begin
        op_a = bus.req_a[32*k +: 32];
        op_b = bus.req_b[32*k +: 32];
      end
    end
  end

  adder_32bit u_adder (
    .A   (op_a),
    .B   (op_b),
    .S   (sum),
    .C32 (c32)
  );

  // Capture result on a transfer, otherwise drop valid on a drain; advance ptr past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_c32_q   <= 1'b0;
      res_id_q    <= '0;
      ptr         <= '0;
      op_count_q  <= '0;
    end else if (xfer) begin
      res_valid_q <= 1'b1;
      res_sum_q   <= sum;
      res_c32_q   <= c32;
      res_id_q    <= grant_id;
      ptr         <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
      op_count_q  <= op_count_q + 16'd1;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_c32   = res_c32_q;
  assign bus.res_id    = res_id_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_adder_32bit_arbiter.sv
// Directed-vector bench for the round-robin shared-adder arbiter.
module tb_adder_32bit_arbiter;

  logic clk;
  logic rst_n;
  int   vec_count;
  int   miss_count;

  adder_32bit_arbiter_if #(.N(4), .IDW(2)) bus ();

  adder_32bit_arbiter #(.N(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [127:0] a, input logic [127:0] b,
                               input logic rr);
    bus.req_valid = valid;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.res_ready = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  logic [31:0] fair_sum [4];
  logic [31:0] fair_c32 [4];

  initial begin
    vec_count  = 0;
    miss_count = 0;
    rst_n      = 1'b0;
    applyStimulus(4'b1111, '0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset state; grants must stay low even with every requester valid.
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'h0);
    checkOutput("rst_res_sum",   bus.res_sum,        32'h0);
    checkOutput("rst_res_c32",   32'(bus.res_c32),   32'h0);
    checkOutput("rst_res_id",    32'(bus.res_id),    32'h0);
    checkOutput("rst_op_count",  32'(bus.op_count),  32'h0);
    doReset();

    // Requester 2 alone: 5 + 7.
    applyStimulus(4'b0100, {32'h0, 32'h5, 32'h0, 32'h0}, {32'h0, 32'h7, 32'h0, 32'h0}, 1'b1);
    checkOutput("r2_req_ready", 32'(bus.req_ready), 32'h4);
    tick();
    checkOutput("r2_res_valid", 32'(bus.res_valid), 32'h1);
    checkOutput("r2_res_sum",   bus.res_sum,        32'h0000_000C);
    checkOutput("r2_res_c32",   32'(bus.res_c32),   32'h0);
    checkOutput("r2_res_id",    32'(bus.res_id),    32'h2);
    checkOutput("r2_op_count",  32'(bus.op_count),  32'h1);

    // Carry cases; requester 0 alone is granted though ptr sits at 3.
    applyStimulus(4'b0001, {96'h0, 32'hFFFF_FFFF}, {96'h0, 32'h0000_0001}, 1'b1);
    checkOutput("c1_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("c1_res_sum",  bus.res_sum,       32'h0);
    checkOutput("c1_res_c32",  32'(bus.res_c32),  32'h1);
    checkOutput("c1_res_id",   32'(bus.res_id),   32'h0);
    applyStimulus(4'b0010, {64'h0, 32'h8000_0000, 32'h0}, {64'h0, 32'h8000_0000, 32'h0}, 1'b1);
    checkOutput("c2_req_ready", 32'(bus.req_ready), 32'h2);
    tick();
    checkOutput("c2_res_sum",  bus.res_sum,       32'h0);
    checkOutput("c2_res_c32",  32'(bus.res_c32),  32'h1);
    checkOutput("c2_res_id",   32'(bus.res_id),   32'h1);
    checkOutput("c2_op_count", 32'(bus.op_count), 32'h3);

    // Fairness: all four valid from a fresh reset, back-to-back results.
    doReset();
    fair_sum[0] = 32'h0000_0011; fair_c32[0] = 32'h0;
    fair_sum[1] = 32'h0000_0102; fair_c32[1] = 32'h0;
    fair_sum[2] = 32'h0000_1003; fair_c32[2] = 32'h0;
    fair_sum[3] = 32'h0000_0010; fair_c32[3] = 32'h1;
    applyStimulus(4'b1111,
                  {32'hFFFF_FFF0, 32'h0000_1000, 32'h0000_0100, 32'h0000_0010},
                  {32'h0000_0020, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001}, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr%0d_req_ready", i), 32'(bus.req_ready), 32'(1 << i));
      tick();
      checkOutput($sformatf("rr%0d_res_valid", i), 32'(bus.res_valid), 32'h1);
      checkOutput($sformatf("rr%0d_res_id", i),    32'(bus.res_id),    32'(i));
      checkOutput($sformatf("rr%0d_res_sum", i),   bus.res_sum,        fair_sum[i]);
      checkOutput($sformatf("rr%0d_res_c32", i),   32'(bus.res_c32),   fair_c32[i]);
    end
    checkOutput("rr_op_count", 32'(bus.op_count), 32'h4);
    checkOutput("rr_wrap_req_ready", 32'(bus.req_ready), 32'h1);

    // Backpressure: result id 3 held for three cycles while requester 2 waits.
    applyStimulus(4'b0100, {32'h0, 32'h1234_5678, 64'h0}, {32'h0, 32'h1111_1111, 64'h0}, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp%0d_req_ready", i), 32'(bus.req_ready), 32'h0);
      tick();
      checkOutput($sformatf("bp%0d_res_valid", i), 32'(bus.res_valid), 32'h1);
      checkOutput($sformatf("bp%0d_res_sum", i),   bus.res_sum,        32'h0000_0010);
      checkOutput($sformatf("bp%0d_res_id", i),    32'(bus.res_id),    32'h3);
      checkOutput($sformatf("bp%0d_op_count", i),  32'(bus.op_count),  32'h4);
    end
    bus.res_ready = 1'b1;
    #1;
    checkOutput("bp_release_req_ready", 32'(bus.req_ready), 32'h4);
    tick();
    checkOutput("bp_new_res_sum",  bus.res_sum,       32'h2345_6789);
    checkOutput("bp_new_res_id",   32'(bus.res_id),   32'h2);
    checkOutput("bp_new_op_count", 32'(bus.op_count), 32'h5);

    // Drain without a new transfer, then an idle cycle.
    applyStimulus(4'b0000, '0, '0, 1'b1);
    tick();
    checkOutput("drain_res_valid", 32'(bus.res_valid), 32'h0);
    checkOutput("drain_res_sum",   bus.res_sum,        32'h2345_6789);
    checkOutput("drain_res_id",    32'(bus.res_id),    32'h2);
    tick();
    checkOutput("idle_res_valid", 32'(bus.res_valid), 32'h0);
    checkOutput("idle_op_count",  32'(bus.op_count),  32'h5);

    // op_count wrap after 65536 transfers from a fresh reset.
    doReset();
    applyStimulus(4'b0001, {96'h0, 32'h1}, {96'h0, 32'h2}, 1'b1);
    repeat (65535) tick();
    checkOutput("wrap_op_count_ffff", 32'(bus.op_count), 32'h0000_FFFF);
    tick();
    checkOutput("wrap_op_count_0", 32'(bus.op_count), 32'h0);
    checkOutput("wrap_res_sum",    bus.res_sum,       32'h3);

    // Leave ptr at 3 with a held result, then reset asynchronously mid-cycle.
    applyStimulus(4'b0100, {32'h0, 32'h10, 64'h0}, {32'h0, 32'h20, 64'h0}, 1'b1);
    tick();
    checkOutput("pre_rst_res_id",   32'(bus.res_id),   32'h2);
    checkOutput("pre_rst_op_count", 32'(bus.op_count), 32'h1);
    applyStimulus(4'b0000, '0, '0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_res_valid", 32'(bus.res_valid), 32'h0);
    checkOutput("arst_res_sum",   bus.res_sum,        32'h0);
    checkOutput("arst_op_count",  32'(bus.op_count),  32'h0);
    bus.req_valid = 4'b1010;
    bus.req_a     = {32'h7FFF_FFFF, 32'h0, 32'h0000_0064, 32'h0};
    bus.req_b     = {32'h0000_0001, 32'h0, 32'h0000_00C8, 32'h0};
    bus.res_ready = 1'b1;
    #1;
    checkOutput("arst_req_ready", 32'(bus.req_ready), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_req_ready", 32'(bus.req_ready), 32'h2);
    tick();
    checkOutput("post_rst_res_id",  32'(bus.res_id),  32'h1);
    checkOutput("post_rst_res_sum", bus.res_sum,      32'h0000_012C);
    checkOutput("post_rst_next_req_ready", 32'(bus.req_ready), 32'h8);
    tick();
    checkOutput("post_rst2_res_id",  32'(bus.res_id),  32'h3);
    checkOutput("post_rst2_res_sum", bus.res_sum,      32'h8000_0000);
    checkOutput("post_rst2_res_c32", 32'(bus.res_c32), 32'h0);
    checkOutput("post_rst2_op_count", 32'(bus.op_count), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
